// File: rtl/lvds_pixel_tx.sv
// 7:1 FPD-Link / OpenLDI LVDS transmitter core: one pixel per 7 bit clocks, VESA or JEIDA mapping.
// Optional underflow counter ports are enabled by defining LVDS_PIXEL_TX_UFLOW_CNT_EN.
module lvds_pixel_tx #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned MAP_JEIDA = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 pix_de,
    input  logic                 pix_hs,
    input  logic                 pix_vs,
    input  logic [7:0]           pix_r,
    input  logic [7:0]           pix_g,
    input  logic [7:0]           pix_b,
    output logic [NUM_LANES-1:0] ser_out,
    output logic                 clk_out,
    output logic                 underflow
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
    ,
    output logic [15:0]          underflow_count,
    input  logic                 underflow_clr
`endif
);

    localparam int unsigned O = (NUM_LANES == 3 || MAP_JEIDA != 0) ? 2 : 0;
    localparam int unsigned E = (MAP_JEIDA != 0) ? 0 : 6;

    logic [2:0] ph;
    logic       load;
    logic       accept;
    logic       clk_pat;

    logic       hold_full;
    logic       hold_de, hold_hs, hold_vs;
    logic [7:0] hold_r, hold_g, hold_b;
    logic       last_hs, last_vs;

    logic       src_de, src_hs, src_vs;
    logic [7:0] src_r, src_g, src_b;
    logic [6:0] wrd [4];
    logic [6:0] sr  [NUM_LANES];

    assign load   = (ph == 3'd6);
    // pix_ready is gated by rst so it reads 0 while the core is held in reset.
    assign pix_ready = !rst && (!hold_full || load);
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        clk_pat = 1'b0;
        case (ph)
            3'd0, 3'd1, 3'd5, 3'd6: clk_pat = 1'b1;
            default:                clk_pat = 1'b0;
        endcase
    end

    assign clk_out = !rst && clk_pat;

    // Blank word: no DE, black, sync lines continue at their last transmitted level.
    always_comb begin
        src_de = hold_full && hold_de;
        src_hs = hold_full ? hold_hs : last_hs;
        src_vs = hold_full ? hold_vs : last_vs;
        src_r  = hold_full ? hold_r : '0;
        src_g  = hold_full ? hold_g : '0;
        src_b  = hold_full ? hold_b : '0;

        // bit s of each word is the slot transmitted while ph == s
        wrd[0] = {src_r[O], src_r[O+1], src_r[O+2], src_r[O+3], src_r[O+4], src_r[O+5], src_g[O]};
        wrd[1] = {src_g[O+1], src_g[O+2], src_g[O+3], src_g[O+4], src_g[O+5], src_b[O], src_b[O+1]};
        wrd[2] = {src_b[O+2], src_b[O+3], src_b[O+4], src_b[O+5], src_hs, src_vs, src_de};
        wrd[3] = {src_r[E], src_r[E+1], src_g[E], src_g[E+1], src_b[E], src_b[E+1], 1'b0};
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            ser_out[k] = sr[k][0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph        <= '0;
            hold_full <= 1'b0;
            hold_de   <= 1'b0;
            hold_hs   <= 1'b0;
            hold_vs   <= 1'b0;
            hold_r    <= '0;
            hold_g    <= '0;
            hold_b    <= '0;
            last_hs   <= 1'b0;
            last_vs   <= 1'b0;
            underflow <= 1'b0;
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                sr[k] <= '0;
            end
        end else begin
            ph        <= load ? 3'd0 : ph + 3'd1;
            underflow <= load && !hold_full;

            if (load) begin
                for (int unsigned k = 0; k < NUM_LANES; k++) begin
                    sr[k] <= wrd[k];
                end
                if (hold_full) begin
                    last_hs <= hold_hs;
                    last_vs <= hold_vs;
                end
            end else begin
                for (int unsigned k = 0; k < NUM_LANES; k++) begin
                    sr[k] <= {1'b0, sr[k][6:1]};
                end
            end

            // An accept on the load edge refills hold after its old contents were consumed.
            if (accept) begin
                hold_full <= 1'b1;
                hold_de   <= pix_de;
                hold_hs   <= pix_hs;
                hold_vs   <= pix_vs;
                hold_r    <= pix_r;
                hold_g    <= pix_g;
                hold_b    <= pix_b;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_count <= '0;
        end else if (underflow_clr) begin
            underflow_count <= {15'd0, underflow};
        end else if (underflow && underflow_count != 16'hFFFF) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lvds_pixel_tx.sv
// Randomized bench for lvds_pixel_tx: four configurations (4/3 lanes x VESA/JEIDA) share one stimulus
// stream and are compared against a slot-level reference model built from the bit-mapping tables.
module tb_lvds_pixel_tx;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_valid = 1'b0;
    logic       pix_de = 1'b0, pix_hs = 1'b0, pix_vs = 1'b0;
    logic [7:0] pix_r = '0, pix_g = '0, pix_b = '0;

    logic [3:0] rdy, cko, ufl;
    logic [3:0] ser_v4, ser_j4;
    logic [2:0] ser_v3, ser_j3;
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
    logic [15:0] ucnt [4];
    logic        uclr = 1'b0;
    logic [15:0] m_cnt;
`endif

    always #5 clk = ~clk;

    lvds_pixel_tx #(.NUM_LANES(4), .MAP_JEIDA(0)) dut_v4 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(rdy[0]),
        .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .ser_out(ser_v4), .clk_out(cko[0]), .underflow(ufl[0])
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
        , .underflow_count(ucnt[0]), .underflow_clr(uclr)
`endif
    );

    lvds_pixel_tx #(.NUM_LANES(4), .MAP_JEIDA(1)) dut_j4 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(rdy[1]),
        .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .ser_out(ser_j4), .clk_out(cko[1]), .underflow(ufl[1])
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
        , .underflow_count(ucnt[1]), .underflow_clr(uclr)
`endif
    );

    lvds_pixel_tx #(.NUM_LANES(3), .MAP_JEIDA(0)) dut_v3 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(rdy[2]),
        .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .ser_out(ser_v3), .clk_out(cko[2]), .underflow(ufl[2])
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
        , .underflow_count(ucnt[2]), .underflow_clr(uclr)
`endif
    );

    lvds_pixel_tx #(.NUM_LANES(3), .MAP_JEIDA(1)) dut_j3 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(rdy[3]),
        .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .ser_out(ser_j3), .clk_out(cko[3]), .underflow(ufl[3])
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
        , .underflow_count(ucnt[3]), .underflow_clr(uclr)
`endif
    );

    int          checks = 0;
    int          failures = 0;

    // reference model state, all expressed per pixel period
    int unsigned cyc;
    logic        m_full, m_uf, m_last_hs, m_last_vs;
    pix_t        m_hold, m_cur, src;
    logic        pend;

    int          acc_count, acc_off_ph6;
    logic        cap_en;
    logic [6:0]  cap_v4l0, cap_j4l0, cap_v4l2;
    logic        uf_mask_en;
    logic [20:0] uf_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic logic exp_bit(input pix_t p, input int lane, input int slot,
                                     input int nl, input int jeida);
        int         o, e;
        logic [7:0] r, g, b;
        r = p.r; g = p.g; b = p.b;
        o = (nl == 3 || jeida != 0) ? 2 : 0;
        e = (jeida != 0) ? 0 : 6;
        case (lane)
            0: return (slot == 0) ? g[o] : r[o + 6 - slot];
            1: return (slot == 0) ? b[o + 1] : (slot == 1) ? b[o] : g[o + 7 - slot];
            2: case (slot)
                   0: return p.de;
                   1: return p.vs;
                   2: return p.hs;
                   default: return b[o + 8 - slot];
               endcase
            default: case (slot)
                   0: return 1'b0;
                   1: return b[e + 1];
                   2: return b[e];
                   3: return g[e + 1];
                   4: return g[e];
                   5: return r[e + 1];
                   default: return r[e];
               endcase
        endcase
    endfunction

    function automatic logic [3:0] exp_ser(input int nl, input int jeida);
        logic [3:0] v;
        v = '0;
        for (int l = 0; l < nl; l++) v[l] = exp_bit(m_cur, l, int'(cyc % 7), nl, jeida);
        return v;
    endfunction

    task automatic model_reset();
        cyc = 0; m_full = 1'b0; m_uf = 1'b0; m_last_hs = 1'b0; m_last_vs = 1'b0;
        m_hold = '0; m_cur = '0; pend = 1'b0; pix_valid = 1'b0;
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
        m_cnt = '0;
`endif
    endtask

    task automatic check_reset();
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", rdy[i], 0);
            check("rst_clk_out", cko[i], 0);
            check("rst_underflow", ufl[i], 0);
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
            check("rst_ucount", ucnt[i], 0);
`endif
        end
        check("rst_ser_v4", ser_v4, 0);
        check("rst_ser_j4", ser_j4, 0);
        check("rst_ser_v3", ser_v3, 0);
        check("rst_ser_j3", ser_j3, 0);
    endtask

    task automatic check_outputs();
        int   ph;
        logic e_clk, e_rdy;
        ph    = int'(cyc % 7);
        e_clk = (ph <= 1 || ph >= 5);
        e_rdy = !m_full || ph == 6;
        for (int i = 0; i < 4; i++) begin
            check("pix_ready", rdy[i], e_rdy);
            check("clk_out", cko[i], e_clk);
            check("underflow", ufl[i], m_uf);
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
            check("underflow_count", ucnt[i], m_cnt);
`endif
        end
        check("ser_v4", ser_v4, exp_ser(4, 0));
        check("ser_j4", ser_j4, exp_ser(4, 1));
        check("ser_v3", ser_v3, exp_ser(3, 0));
        check("ser_j3", ser_j3, exp_ser(3, 1));
        if (cap_en) begin
            cap_v4l0[ph] = ser_v4[0];
            cap_j4l0[ph] = ser_j4[0];
            cap_v4l2[ph] = ser_v4[2];
        end
        if (uf_mask_en && cyc < 21) uf_mask[cyc] = ufl[0];
    endtask

    task automatic drive(input bit want, input bit fixed, input pix_t fp, input bit clr);
        logic [31:0] rv;
        if (!pend && want) begin
            rv  = $urandom;
            src = fixed ? fp : pix_t'(rv[26:0]);
            pend = 1'b1;
        end
        pix_valid = pend;
        pix_de = src.de; pix_hs = src.hs; pix_vs = src.vs;
        pix_r = src.r; pix_g = src.g; pix_b = src.b;
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
        uclr = clr;
`else
        if (clr) pix_valid = pend;
`endif
    endtask

    // Advance the model across one clock edge using the spec rules for accept and frame load.
    task automatic model_update();
        int   ph;
        logic acc, uf_n;
        ph   = int'(cyc % 7);
        acc  = pend && (!m_full || ph == 6);
        uf_n = 1'b0;
`ifdef LVDS_PIXEL_TX_UFLOW_CNT_EN
        if (uclr) m_cnt = {15'd0, m_uf};
        else if (m_uf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        if (ph == 6) begin
            if (m_full) begin
                m_cur = m_hold;
                m_last_hs = m_hold.hs;
                m_last_vs = m_hold.vs;
            end else begin
                m_cur = '0;
                m_cur.hs = m_last_hs;
                m_cur.vs = m_last_vs;
                uf_n = 1'b1;
            end
            m_full = acc;
        end else if (acc) begin
            m_full = 1'b1;
        end
        if (acc) begin
            m_hold = src;
            pend = 1'b0;
            acc_count++;
            if (ph != 6) acc_off_ph6++;
        end
        m_uf = uf_n;
        cyc++;
    endtask

    task automatic step(input bit want, input bit fixed, input pix_t fp, input bit clr);
        check_outputs();
        drive(want, fixed, fp, clr);
        model_update();
        @(negedge clk);
        #1;
    endtask

    initial begin
        pix_t px;
        int   n;
        cap_en = 1'b0; uf_mask_en = 1'b0; uf_mask = '0;
        cap_v4l0 = '0; cap_j4l0 = '0; cap_v4l2 = '0;
        acc_count = 0; acc_off_ph6 = 0;
        src = '0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        #1;

        // idle after release: clock pattern, blank frames, underflow at cycles 7 and 14
        uf_mask_en = 1'b1;
        repeat (21) step(1'b0, 1'b0, '0, 1'b0);
        uf_mask_en = 1'b0;
        check("idle_uf_cycles", uf_mask, 21'h004080);

        // steady A5/3C/0F stream
        px = '{de: 1'b1, hs: 1'b0, vs: 1'b1, r: 8'hA5, g: 8'h3C, b: 8'h0F};
        for (int i = 0; i < 35; i++) begin
            cap_en = (i >= 28);
            step(1'b1, 1'b1, px, 1'b0);
        end
        cap_en = 1'b0;
        check("vesa_lane0", cap_v4l0, 7'b1010010);
        check("jeida_lane0", cap_j4l0, 7'b1001011);
        check("vesa_lane2_ctl", cap_v4l2[2:0], 3'b011);

        // 18-bit stream with R=FC
        px = '{de: 1'b1, hs: 1'b1, vs: 1'b0, r: 8'hFC, g: 8'h00, b: 8'h00};
        repeat (21) step(1'b1, 1'b1, px, 1'b0);

        // random traffic with occasional counter clears
        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 99) < 55), 1'b0, '0, ($urandom_range(0, 99) < 4));
        end

        // back-pressure: once hold is full, a continuous source gets one accept per frame on ph 6
        n = 0;
        while (!m_full && n < 30) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n++;
        end
        check("bp_hold_filled", m_full, 1);
        acc_count = 0; acc_off_ph6 = 0;
        repeat (21) step(1'b1, 1'b0, '0, 1'b0);
        check("bp_accepts", acc_count, 3);
        check("bp_off_ph6", acc_off_ph6, 0);

        // reset mid-frame at ph 3 with hold full
        n = 0;
        while (!(cyc % 7 == 3 && m_full) && n < 40) begin
            step(1'b1, 1'b0, '0, 1'b0);
            n++;
        end
        check("midrst_reached", (cyc % 7 == 3 && m_full), 1);
        rst = 1'b1;
        #1;
        check_reset();
        @(negedge clk);
        #1;
        check_reset();
        model_reset();
        rst = 1'b0;
        #1;
        repeat (120) step(($urandom_range(0, 99) < 40), 1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
